pep_batch_unpack: RTL and testbench

Reader end of the PBS batch path. The batch former writes batch commands of up to BATCH_PBS_NB consecutive PBS ids. This block consumes them when the processing pipe retires a batch and emits one per-PBS "done" beat per cycle, tagged with pid and GRAM id, toward the sample-extract/slot-release logic. It also frees PBS storage slots back to the TOTAL_PBS_NB ring.

---
 rtl/pep_batch_unpack_pkg.sv | 14 +
 rtl/pep_batch_cmd_fifo.sv | 39 +++
 rtl/pep_batch_unpack.sv | 81 ++++++++
 tb/tb_pep_batch_unpack.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pep_batch_unpack_pkg.sv
// pep_batch_unpack_pkg: shared sizing and batch command type for the PBS batch path
package pep_batch_unpack_pkg;
  localparam int BATCH_PBS_NB = 8;
  localparam int TOTAL_PBS_NB = 16;
  localparam int GRAM_NB = 4;
  localparam int CMD_FIFO_DEPTH = 2;
  localparam int PID_W = $clog2(TOTAL_PBS_NB);
  localparam int BNB_W = $clog2(BATCH_PBS_NB + 1);
  localparam int GID_W = $clog2(GRAM_NB) > 1 ? $clog2(GRAM_NB) : 1;
  typedef struct packed {
    logic [PID_W-1:0] first_pid;
    logic [BNB_W-1:0] pbs_nb;
  } batch_cmd_t;
endpackage

// File: rtl/pep_batch_cmd_fifo.sv
// pep_batch_cmd_fifo: register FIFO of batch_cmd_t, vld/rdy both sides, rdy low during rst and when full
module pep_batch_cmd_fifo
  import pep_batch_unpack_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  output logic       in_rdy,
  input  batch_cmd_t in_data,
  output logic       out_vld,
  input  logic       out_rdy,
  output batch_cmd_t out_data
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  batch_cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign in_rdy = !rst && cnt != CW'(DEPTH);
  assign out_vld = cnt != '0;
  assign out_data = mem[rp];
  assign push = in_vld && in_rdy;
  assign pop = out_vld && out_rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? (wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1)) : wp;
      rp <= pop ? (rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1)) : rp;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
    if (push) mem[wp] <= in_data;
  end
endmodule

// File: rtl/pep_batch_unpack.sv
// pep_batch_unpack: unpacks batch commands into per-PBS done beats (pid, gid, last, done, slot free); PEP_BATCH_UNPACK_STATS_EN adds stat counters
module pep_batch_unpack
  import pep_batch_unpack_pkg::*;
(
  input  logic             clk,
  input  logic             s_rst,
  input  logic             in_batch_vld,
  output logic             in_batch_rdy,
  input  logic [PID_W-1:0] in_batch_first_pid,
  input  logic [BNB_W-1:0] in_batch_pbs_nb,
  output logic             out_pbs_vld,
  input  logic             out_pbs_rdy,
  output logic [PID_W-1:0] out_pbs_pid,
  output logic [GID_W-1:0] out_pbs_gid,
  output logic             out_pbs_last,
  output logic             out_batch_done,
  output logic [PID_W:0]   out_free_slot_nb,
  output logic             error,
  output logic [31:0]      stat_batch_cnt,
  output logic [31:0]      stat_pbs_cnt
);
  typedef enum logic {IDLE, UNPACK} state_t;
  state_t state;
  batch_cmd_t in_cmd, head;
  logic head_vld, pop, hs, legal;
  logic [BNB_W-1:0] rem;
  assign in_cmd = {in_batch_first_pid, in_batch_pbs_nb};
  pep_batch_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (s_rst),
    .in_vld   (in_batch_vld),
    .in_rdy   (in_batch_rdy),
    .in_data  (in_cmd),
    .out_vld  (head_vld),
    .out_rdy  (pop),
    .out_data (head)
  );
  assign out_pbs_vld = state == UNPACK;
  assign out_pbs_last = out_pbs_vld && rem == '0;
  assign hs = out_pbs_vld && out_pbs_rdy;
  assign out_batch_done = hs && out_pbs_last;
  assign out_free_slot_nb = (PID_W + 1)'(hs);
  assign legal = head.pbs_nb != '0 && head.pbs_nb <= BNB_W'(BATCH_PBS_NB);
  assign pop = head_vld && (state == IDLE || out_batch_done);
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state <= IDLE;
      out_pbs_pid <= '0;
      out_pbs_gid <= '0;
      rem <= '0;
      error <= 1'b0;
    end else begin
      if (pop && legal) begin
        state <= UNPACK;
        out_pbs_pid <= head.first_pid;
        out_pbs_gid <= GID_W'(32'(head.first_pid) % 32'(GRAM_NB));
        rem <= head.pbs_nb - BNB_W'(1);
      end else if (hs) begin
        state <= out_pbs_last ? IDLE : UNPACK;
        out_pbs_pid <= out_pbs_pid == PID_W'(TOTAL_PBS_NB - 1) ? '0 : out_pbs_pid + PID_W'(1);
        out_pbs_gid <= out_pbs_gid == GID_W'(GRAM_NB - 1) ? '0 : out_pbs_gid + GID_W'(1);
        rem <= out_pbs_last ? '0 : rem - BNB_W'(1);
      end
      if (pop && !legal) error <= 1'b1;
    end
  end
`ifdef PEP_BATCH_UNPACK_STATS_EN
  always_ff @(posedge clk) begin
    if (s_rst) begin
      stat_batch_cnt <= '0;
      stat_pbs_cnt <= '0;
    end else begin
      stat_batch_cnt <= stat_batch_cnt + 32'(out_batch_done);
      stat_pbs_cnt <= stat_pbs_cnt + 32'(hs);
    end
  end
`else
  assign stat_batch_cnt = '0;
  assign stat_pbs_cnt = '0;
`endif
endmodule

// File: tb/tb_pep_batch_unpack.sv
// tb_pep_batch_unpack: directed and randomized checks of pep_batch_unpack against a beat-queue model
module tb_pep_batch_unpack;
  import pep_batch_unpack_pkg::*;
  logic clk = 0;
  logic s_rst = 1;
  logic in_batch_vld = 0;
  logic in_batch_rdy;
  logic [PID_W-1:0] in_batch_first_pid = '0;
  logic [BNB_W-1:0] in_batch_pbs_nb = '0;
  logic out_pbs_vld, out_pbs_rdy, out_pbs_last, out_batch_done, error;
  logic [PID_W-1:0] out_pbs_pid;
  logic [GID_W-1:0] out_pbs_gid;
  logic [PID_W:0] out_free_slot_nb;
  logic [31:0] stat_batch_cnt, stat_pbs_cnt;
  always #5 clk = ~clk;
  pep_batch_unpack dut (
    .clk                (clk),
    .s_rst              (s_rst),
    .in_batch_vld       (in_batch_vld),
    .in_batch_rdy       (in_batch_rdy),
    .in_batch_first_pid (in_batch_first_pid),
    .in_batch_pbs_nb    (in_batch_pbs_nb),
    .out_pbs_vld        (out_pbs_vld),
    .out_pbs_rdy        (out_pbs_rdy),
    .out_pbs_pid        (out_pbs_pid),
    .out_pbs_gid        (out_pbs_gid),
    .out_pbs_last       (out_pbs_last),
    .out_batch_done     (out_batch_done),
    .out_free_slot_nb   (out_free_slot_nb),
    .error              (error),
    .stat_batch_cnt     (stat_batch_cnt),
    .stat_pbs_cnt       (stat_pbs_cnt)
  );
  typedef struct {
    int pid;
    int gid;
    bit last;
  } beat_t;
  beat_t exp_q[$];
  beat_t b, e;
  int cap_pid[$], cap_gid[$], cap_cyc[$];
  int n_done, n_free, cyc;
  bit exp_err;
  int exp_batches, exp_pbs;
  bit rnd_rdy, rdy_force;
  bit stall, st_last;
  int st_pid, st_gid;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  function automatic longint stat_exp(input int v);
`ifdef PEP_BATCH_UNPACK_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction
  always @(posedge clk) begin
    #1;
    out_pbs_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end
  always @(negedge clk) begin
    cyc++;
    if (s_rst) stall = 0;
    else begin
      if (in_batch_vld && in_batch_rdy) begin
        if (in_batch_pbs_nb >= 1 && in_batch_pbs_nb <= BATCH_PBS_NB)
          for (int i = 0; i < int'(in_batch_pbs_nb); i++) begin
            b.pid = (int'(in_batch_first_pid) + i) % TOTAL_PBS_NB;
            b.gid = b.pid % GRAM_NB;
            b.last = (i == int'(in_batch_pbs_nb) - 1);
            exp_q.push_back(b);
          end
        else exp_err = 1;
      end
      if (stall) begin
        chk("hold_vld", out_pbs_vld, 1);
        chk("hold_pid", out_pbs_pid, st_pid);
        chk("hold_gid", out_pbs_gid, st_gid);
        chk("hold_last", out_pbs_last, st_last);
      end
      stall = out_pbs_vld && !out_pbs_rdy;
      st_pid = out_pbs_pid;
      st_gid = out_pbs_gid;
      st_last = out_pbs_last;
      chk("stat_batch", stat_batch_cnt, stat_exp(exp_batches));
      chk("stat_pbs", stat_pbs_cnt, stat_exp(exp_pbs));
      if (out_batch_done) n_done++;
      if (out_free_slot_nb == 1) n_free++;
      if (out_pbs_vld && out_pbs_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_beat_pid", out_pbs_pid, -1);
        else begin
          e = exp_q.pop_front();
          chk("beat_pid", out_pbs_pid, e.pid);
          chk("beat_gid", out_pbs_gid, e.gid);
          chk("beat_last", out_pbs_last, e.last);
          chk("beat_done", out_batch_done, e.last);
          chk("beat_free", out_free_slot_nb, 1);
          cap_pid.push_back(int'(out_pbs_pid));
          cap_gid.push_back(int'(out_pbs_gid));
          cap_cyc.push_back(cyc);
          exp_pbs++;
          if (e.last) exp_batches++;
        end
      end else begin
        chk("idle_done", out_batch_done, 0);
        chk("idle_free", out_free_slot_nb, 0);
      end
    end
  end
  task automatic clr();
    cap_pid.delete();
    cap_gid.delete();
    cap_cyc.delete();
    n_done = 0;
    n_free = 0;
  endtask
  task automatic do_reset();
    s_rst = 1;
    in_batch_vld = 0;
    @(posedge clk);
    #1;
    chk("rst_in_rdy", in_batch_rdy, 0);
    chk("rst_vld", out_pbs_vld, 0);
    chk("rst_pid", out_pbs_pid, 0);
    chk("rst_gid", out_pbs_gid, 0);
    chk("rst_last", out_pbs_last, 0);
    chk("rst_done", out_batch_done, 0);
    chk("rst_free", out_free_slot_nb, 0);
    chk("rst_error", error, 0);
    chk("rst_stat_batch", stat_batch_cnt, 0);
    chk("rst_stat_pbs", stat_pbs_cnt, 0);
    exp_q.delete();
    exp_err = 0;
    exp_batches = 0;
    exp_pbs = 0;
    s_rst = 0;
    #1;
    chk("rst_rdy_after", in_batch_rdy, 1);
  endtask
  task automatic push(input int f, input int n);
    int t = 0;
    in_batch_vld = 1;
    in_batch_first_pid = PID_W'(f);
    in_batch_pbs_nb = BNB_W'(n);
    while (!in_batch_rdy && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) chk("push_timeout", t, 0);
    @(posedge clk);
    #1;
    in_batch_vld = 0;
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_pbs_vld) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_timeout", t < 3000, 1);
    chk("drain_left", exp_q.size(), 0);
  endtask
  initial begin
    rdy_force = 1;
    rnd_rdy = 0;
    do_reset();
    clr();
    push(3, 4);
    chk("lat_n1_vld", out_pbs_vld, 0);
    @(posedge clk);
    #1;
    chk("lat_n2_vld", out_pbs_vld, 1);
    chk("lat_n2_pid", out_pbs_pid, 3);
    drain();
    begin
      automatic int ep[4] = '{3, 4, 5, 6};
      automatic int eg[4] = '{3, 0, 1, 2};
      chk("single_n", cap_pid.size(), 4);
      foreach (ep[i]) if (i < cap_pid.size()) begin
        chk("single_pid", cap_pid[i], ep[i]);
        chk("single_gid", cap_gid[i], eg[i]);
      end
      chk("single_done", n_done, 1);
      chk("single_free", n_free, 4);
    end
    clr();
    push(14, 4);
    drain();
    begin
      automatic int ep[4] = '{14, 15, 0, 1};
      automatic int eg[4] = '{2, 3, 0, 1};
      chk("wrap_n", cap_pid.size(), 4);
      foreach (ep[i]) if (i < cap_pid.size()) begin
        chk("wrap_pid", cap_pid[i], ep[i]);
        chk("wrap_gid", cap_gid[i], eg[i]);
      end
    end
    clr();
    push(0, 8);
    push(8, 8);
    drain();
    chk("b2b_n", cap_pid.size(), 16);
    if (cap_pid.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("b2b_pid", cap_pid[i], i);
      chk("b2b_span", cap_cyc[15] - cap_cyc[0], 15);
    end
    chk("b2b_done", n_done, 2);
    clr();
    rdy_force = 0;
    push(5, 3);
    push(0, 1);
    push(1, 1);
    chk("bp_full_rdy", in_batch_rdy, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_vld", out_pbs_vld, 1);
      chk("bp_hold_pid", out_pbs_pid, 5);
    end
    rdy_force = 1;
    drain();
    begin
      automatic int ep[5] = '{5, 6, 7, 0, 1};
      automatic int eg[5] = '{1, 2, 3, 0, 1};
      chk("bp_n", cap_pid.size(), 5);
      foreach (ep[i]) if (i < cap_pid.size()) begin
        chk("bp_pid", cap_pid[i], ep[i]);
        chk("bp_gid", cap_gid[i], eg[i]);
      end
    end
    clr();
    push(0, 0);
    push(0, 9);
    push(2, 1);
    drain();
    chk("ill_n", cap_pid.size(), 1);
    if (cap_pid.size() == 1) chk("ill_pid", cap_pid[0], 2);
    chk("ill_error", error, 1);
    chk("ill_error_model", error, exp_err);
    push(7, 2);
    drain();
    chk("ill_error_sticky", error, 1);
    rnd_rdy = 1;
    repeat (150) begin
      automatic int nb = ($urandom_range(0, 15) == 0) ?
                         (($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(9, 15))) :
                         int'($urandom_range(1, 8));
      push(int'($urandom_range(0, 15)), nb);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 0;
    drain();
    chk("rnd_error", error, exp_err);
    do_reset();
    clr();
    push(0, 8);
    push(8, 8);
    push(0, 8);
    drain();
    chk("stat3_batch", stat_batch_cnt, stat_exp(3));
    chk("stat3_pbs", stat_pbs_cnt, stat_exp(24));
    clr();
    push(4, 8);
    begin
      automatic int t = 0;
      while (cap_pid.size() < 2 && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("mid_wait", cap_pid.size(), 2);
    end
    do_reset();
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("mid_vld", out_pbs_vld, 0);
    end
    chk("mid_beats", cap_pid.size(), 2);
    chk("mid_done", n_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
